// File: rtl/imm_extend_if.sv
// imm_extend_if: handshake bundle between decode and execute for the immediate generator.
// The slave modport is the generator's view; the master modport is the surrounding pipeline's view.
interface imm_extend_if #(parameter int XLEN = 32, parameter int TAG_W = 32);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [2:0]       immsrc;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  immop;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;
    modport master (
        output in_valid, instr, immsrc, in_tag, out_ready,
        input  in_ready, out_valid, immop, out_tag, out_illegal
    );
    modport slave (
        input  in_valid, instr, immsrc, in_tag, out_ready,
        output in_ready, out_valid, immop, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered RV immediate extender with a 2-entry skid buffer and sideband tag.
// Define IMM_EXT_ZIMM_EN to decode immsrc 101 as the zero-extended CSR zimm instead of illegal.
module imm_extend_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input logic         clk,
    input logic         rst_n,
    input logic         flush,
    imm_extend_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t           state, state_nx;
    logic [XLEN-1:0]  imm_q [2];
    logic [TAG_W-1:0] tag_q [2];
    logic [1:0]       ill_q;
    logic             wr_ptr, rd_ptr;
    logic             accept, pop;
    logic [XLEN-1:0]  ext;
    logic             ill;
    logic             unused;
    assign unused = ^bus.instr[6:0];
    // Sign extension comes from casting the signed immediate field up to XLEN.
    always_comb begin
        ext = '0;
        ill = 1'b0;
        case (bus.immsrc)
            3'b000: ext = XLEN'($signed(bus.instr[31:20]));
            3'b001: ext = XLEN'($signed({bus.instr[31:25], bus.instr[11:7]}));
            3'b010: ext = XLEN'($signed({bus.instr[31], bus.instr[7], bus.instr[30:25], bus.instr[11:8], 1'b0}));
            3'b011: ext = XLEN'($signed({bus.instr[31:12], 12'b0}));
            3'b100: ext = XLEN'($signed({bus.instr[31], bus.instr[19:12], bus.instr[20], bus.instr[30:21], 1'b0}));
`ifdef IMM_EXT_ZIMM_EN
            3'b101: ext = XLEN'(bus.instr[19:15]);
`endif
            default: ill = 1'b1;
        endcase
    end
    assign accept = bus.in_valid && bus.in_ready;
    assign pop    = bus.out_valid && bus.out_ready;
    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = EMPTY;
        else if (accept && !pop)
            state_nx = (state == EMPTY) ? ONE : FULL;
        else if (pop && !accept)
            state_nx = (state == FULL) ? ONE : EMPTY;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= EMPTY;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            imm_q  <= '{default: '0};
            tag_q  <= '{default: '0};
            ill_q  <= '0;
        end else begin
            state <= state_nx;
            if (flush) begin
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
            end else begin
                if (accept) begin
                    imm_q[wr_ptr] <= ext;
                    tag_q[wr_ptr] <= bus.in_tag;
                    ill_q[wr_ptr] <= ill;
                    wr_ptr        <= ~wr_ptr;
                end
                if (pop)
                    rd_ptr <= ~rd_ptr;
            end
        end
    end
    // Ready depends only on registered occupancy, never on out_ready.
    assign bus.in_ready    = (state != FULL);
    assign bus.out_valid   = (state != EMPTY);
    assign bus.immop       = imm_q[rd_ptr];
    assign bus.out_tag     = tag_q[rd_ptr];
    assign bus.out_illegal = ill_q[rd_ptr];
endmodule

// File: tb/tb_imm_extend_pipe.sv
// tb_imm_extend_pipe: directed vector table plus hand-written backpressure, flush and reset sequences.
// Instantiates an XLEN=32 and an XLEN=64 copy of the generator.
module tb_imm_extend_pipe;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   checks = 0;
    int   errors = 0;
    imm_extend_if #(.XLEN(32), .TAG_W(32)) b ();
    imm_extend_if #(.XLEN(64), .TAG_W(32)) c ();
    imm_extend_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(b.slave));
    imm_extend_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .flush(1'b0), .bus(c.slave));
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [31:0] exp;
        logic        ill;
    } vec_t;
    vec_t v [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic offer(input logic [31:0] instr, input logic [2:0] src, input logic [31:0] tag);
        b.in_valid = 1'b1;
        b.instr    = instr;
        b.immsrc   = src;
        b.in_tag   = tag;
    endtask

    initial begin
        v[0]  = '{32'hFFF00093, 3'b000, 32'hFFFFFFFF, 1'b0};
        v[1]  = '{32'hFE000EE3, 3'b010, 32'hFFFFFFFC, 1'b0};
        v[2]  = '{32'h0080006F, 3'b100, 32'h00000008, 1'b0};
        v[3]  = '{32'h123450B7, 3'b011, 32'h12345000, 1'b0};
        v[4]  = '{32'h00500093, 3'b000, 32'h00000005, 1'b0};
        v[5]  = '{32'h0020A423, 3'b001, 32'h00000008, 1'b0};
        v[6]  = '{32'hFE000E23, 3'b001, 32'hFFFFFFFC, 1'b0};
        v[7]  = '{32'hFFDFF06F, 3'b100, 32'hFFFFFFFC, 1'b0};
        v[8]  = '{32'h800000B7, 3'b011, 32'h80000000, 1'b0};
        v[9]  = '{32'hFFFFFFFF, 3'b110, 32'h00000000, 1'b1};
        v[10] = '{32'hFFFFFFFF, 3'b111, 32'h00000000, 1'b1};
`ifdef IMM_EXT_ZIMM_EN
        v[11] = '{32'h800F8073, 3'b101, 32'h0000001F, 1'b0};
`else
        v[11] = '{32'h800F8073, 3'b101, 32'h00000000, 1'b1};
`endif
        b.in_valid = 1'b0; b.instr = '0; b.immsrc = '0; b.in_tag = '0; b.out_ready = 1'b0;
        c.in_valid = 1'b0; c.instr = '0; c.immsrc = '0; c.in_tag = '0; c.out_ready = 1'b0;
        step();
        step();
        chk("rst out_valid", 64'(b.out_valid), 64'd0);
        chk("rst in_ready", 64'(b.in_ready), 64'd1);
        chk("rst immop", 64'(b.immop), 64'd0);
        chk("rst out_tag", 64'(b.out_tag), 64'd0);
        rst_n = 1'b1;

        // Streaming with out_ready high: each entry appears the cycle after it is accepted.
        b.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            offer(v[i].instr, v[i].src, 32'hA000_0000 + i);
            step();
            chk($sformatf("vec%0d out_valid", i), 64'(b.out_valid), 64'd1);
            chk($sformatf("vec%0d in_ready", i), 64'(b.in_ready), 64'd1);
            chk($sformatf("vec%0d immop", i), 64'(b.immop), 64'(v[i].exp));
            chk($sformatf("vec%0d illegal", i), 64'(b.out_illegal), 64'(v[i].ill));
            chk($sformatf("vec%0d tag", i), 64'(b.out_tag), 64'(32'hA000_0000 + i));
        end
        b.in_valid = 1'b0;
        step();
        chk("drain out_valid", 64'(b.out_valid), 64'd0);

        // Backpressure: third offer is held until a slot frees up.
        b.out_ready = 1'b0;
        offer(32'h00100093, 3'b000, 32'd1);
        step();
        chk("bp1 out_valid", 64'(b.out_valid), 64'd1);
        chk("bp1 in_ready", 64'(b.in_ready), 64'd1);
        offer(32'h00200093, 3'b000, 32'd2);
        step();
        chk("bp2 in_ready", 64'(b.in_ready), 64'd0);
        chk("bp2 head tag", 64'(b.out_tag), 64'd1);
        offer(32'h00300093, 3'b000, 32'd3);
        step();
        chk("bp3 in_ready", 64'(b.in_ready), 64'd0);
        chk("bp3 head held", 64'(b.immop), 64'd1);
        b.out_ready = 1'b1;
        step();
        chk("bp4 head tag", 64'(b.out_tag), 64'd2);
        chk("bp4 in_ready", 64'(b.in_ready), 64'd1);
        step();
        b.in_valid = 1'b0;
        chk("bp5 head tag", 64'(b.out_tag), 64'd3);
        chk("bp5 immop", 64'(b.immop), 64'd3);
        step();
        chk("bp6 out_valid", 64'(b.out_valid), 64'd0);

        // Flush while full, with a competing offer that must be dropped.
        b.out_ready = 1'b0;
        offer(32'h00400093, 3'b000, 32'd4);
        step();
        offer(32'h00500093, 3'b000, 32'd5);
        step();
        chk("fl full", 64'(b.in_ready), 64'd0);
        offer(32'h00600093, 3'b000, 32'd6);
        flush = 1'b1;
        step();
        flush = 1'b0;
        b.in_valid = 1'b0;
        b.out_ready = 1'b1;
        chk("fl out_valid", 64'(b.out_valid), 64'd0);
        chk("fl in_ready", 64'(b.in_ready), 64'd1);
        step();
        chk("fl stays empty", 64'(b.out_valid), 64'd0);
        offer(32'h00700093, 3'b000, 32'd7);
        step();
        b.in_valid = 1'b0;
        chk("fl next tag", 64'(b.out_tag), 64'd7);
        chk("fl next immop", 64'(b.immop), 64'd7);

        // XLEN=64 extension, then reset while full.
        c.in_valid = 1'b1; c.instr = 32'h800000B7; c.immsrc = 3'b011; c.in_tag = 32'd77;
        step();
        chk("x64 out_valid", 64'(c.out_valid), 64'd1);
        chk("x64 immop U", c.immop, 64'hFFFFFFFF80000000);
        c.instr = 32'hFFF00093; c.immsrc = 3'b000; c.in_tag = 32'd78;
        step();
        c.in_valid = 1'b0;
        chk("x64 full", 64'(c.in_ready), 64'd0);
        chk("x64 head held", c.immop, 64'hFFFFFFFF80000000);
        c.out_ready = 1'b1;
        step();
        c.out_ready = 1'b0;
        chk("x64 immop I", c.immop, 64'hFFFFFFFFFFFFFFFF);
        c.in_valid = 1'b1; c.instr = 32'h123450B7; c.immsrc = 3'b011; c.in_tag = 32'd79;
        step();
        c.in_valid = 1'b0;
        chk("x64 refull", 64'(c.in_ready), 64'd0);
        rst_n = 1'b0;
        step();
        chk("mrst out_valid", 64'(c.out_valid), 64'd0);
        chk("mrst in_ready", 64'(c.in_ready), 64'd1);
        chk("mrst immop", c.immop, 64'd0);
        chk("mrst out_tag", 64'(c.out_tag), 64'd0);
        chk("mrst illegal", 64'(c.out_illegal), 64'd0);
        rst_n = 1'b1;
        step();
        chk("post rst empty", 64'(c.out_valid), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
